regfile_sequencer: RTL and testbench

Multi-cycle instruction sequencer for the 16-bit datapath built around the 8×16 register file. It accepts one 16-bit instruction per start handshake, decodes it, and steps the register file (`readnum`, `writenum`, `write`) and datapath strobes (A/B/C/status loads, operand and writeback selects) through the read, execute and writeback cycles. It sits between the instruction source (bench or future fetch unit) and the datapath.

---
 rtl/regfile_sequencer.sv | 228 ++++++++++++++++++++++
 tb/tb_regfile_sequencer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sequencer.sv
// regfile_sequencer: multi-cycle control FSM for the 16-bit datapath.
// Accepts one instruction per start handshake in WAIT, then walks the
// register file and datapath strobes through read, execute and writeback.
// Strobe outputs are held in registers that are loaded with the values
// belonging to the state being entered. Writes and loads are additionally
// masked by reset, so that nothing updates on an edge where reset is high.
module regfile_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        s,
    input  logic [15:0] in,
    output logic        w,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic        write,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        asel,
    output logic        bsel,
    output logic [1:0]  vsel,
    output logic [1:0]  shift,
    output logic [1:0]  aluop,
    output logic [15:0] sximm8
);

    typedef enum logic [2:0] {
        S_WAIT   = 3'd0,
        S_DECODE = 3'd1,
        S_GET_A  = 3'd2,
        S_GET_B  = 3'd3,
        S_ALU    = 3'd4,
        S_WR_REG = 3'd5,
        S_WR_IMM = 3'd6
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] ir_q, ir_d;

    logic        w_q, w_d;
    logic [2:0]  readnum_q, readnum_d;
    logic [2:0]  writenum_q, writenum_d;
    logic        write_q, write_d;
    logic        loada_q, loada_d;
    logic        loadb_q, loadb_d;
    logic        loadc_q, loadc_d;
    logic        loads_q, loads_d;
    logic        asel_q, asel_d;
    logic [1:0]  vsel_q, vsel_d;
    logic [1:0]  shift_q, shift_d;
    logic [1:0]  aluop_q, aluop_d;

    // Instruction fields of the captured instruction
    logic [2:0] opcode_s;
    logic [1:0] op_s;
    logic [2:0] rn_s;
    logic [2:0] rd_s;
    logic [1:0] sh_s;
    logic [2:0] rm_s;

    assign opcode_s = ir_q[15:13];
    assign op_s     = ir_q[12:11];
    assign rn_s     = ir_q[10:8];
    assign rd_s     = ir_q[7:5];
    assign sh_s     = ir_q[4:3];
    assign rm_s     = ir_q[2:0];

    // Instruction classes
    logic is_mov_imm_s;
    logic is_mov_reg_s;
    logic is_alu_s;
    logic is_cmp_s;
    logic is_mvn_s;

    assign is_mov_imm_s = (opcode_s == 3'b110) && (op_s == 2'b10);
    assign is_mov_reg_s = (opcode_s == 3'b110) && (op_s == 2'b00);
    assign is_alu_s     = (opcode_s == 3'b101);
    assign is_cmp_s     = is_alu_s && (op_s == 2'b01);
    assign is_mvn_s     = is_alu_s && (op_s == 2'b11);

    // Next-state and instruction capture
    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        case (state_q)
            S_WAIT: begin
                if (s) begin
                    state_d = S_DECODE;
                    ir_d    = in;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_DECODE: begin
                if (is_mov_imm_s) begin
                    state_d = S_WR_IMM;
                end else if (is_mov_reg_s || is_mvn_s) begin
                    state_d = S_GET_B;
                end else if (is_alu_s) begin
                    state_d = S_GET_A;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_GET_A:  state_d = S_GET_B;
            S_GET_B:  state_d = S_ALU;
            S_ALU: begin
                if (is_cmp_s) begin
                    state_d = S_WAIT;
                end else begin
                    state_d = S_WR_REG;
                end
            end
            S_WR_REG: state_d = S_WAIT;
            S_WR_IMM: state_d = S_WAIT;
            default:  state_d = S_WAIT;
        endcase
    end

    // Moore output values for the state being entered; DECODE drives nothing,
    // so the freshly captured instruction is never needed on the accepting edge
    always_comb begin
        w_d        = 1'b0;
        readnum_d  = 3'd0;
        writenum_d = 3'd0;
        write_d    = 1'b0;
        loada_d    = 1'b0;
        loadb_d    = 1'b0;
        loadc_d    = 1'b0;
        loads_d    = 1'b0;
        asel_d     = 1'b0;
        vsel_d     = 2'b00;
        shift_d    = 2'b00;
        aluop_d    = 2'b00;
        case (state_d)
            S_WAIT: begin
                w_d = 1'b1;
            end
            S_GET_A: begin
                readnum_d = rn_s;
                loada_d   = 1'b1;
            end
            S_GET_B: begin
                readnum_d = rm_s;
                loadb_d   = 1'b1;
            end
            S_ALU: begin
                shift_d = sh_s;
                if (is_mov_reg_s) begin
                    aluop_d = 2'b00;
                end else begin
                    aluop_d = op_s;
                end
                asel_d  = is_mov_reg_s || is_mvn_s;
                loadc_d = !is_cmp_s;
                loads_d = is_cmp_s;
            end
            S_WR_REG: begin
                writenum_d = rd_s;
                vsel_d     = 2'b00;
                write_d    = 1'b1;
            end
            S_WR_IMM: begin
                writenum_d = rn_s;
                vsel_d     = 2'b10;
                write_d    = 1'b1;
            end
            default: begin
                w_d = 1'b0;
            end
        endcase
    end

    // State, instruction register and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_WAIT;
            ir_q       <= 16'h0000;
            w_q        <= 1'b1;
            readnum_q  <= 3'd0;
            writenum_q <= 3'd0;
            write_q    <= 1'b0;
            loada_q    <= 1'b0;
            loadb_q    <= 1'b0;
            loadc_q    <= 1'b0;
            loads_q    <= 1'b0;
            asel_q     <= 1'b0;
            vsel_q     <= 2'b00;
            shift_q    <= 2'b00;
            aluop_q    <= 2'b00;
        end else begin
            state_q    <= state_d;
            ir_q       <= ir_d;
            w_q        <= w_d;
            readnum_q  <= readnum_d;
            writenum_q <= writenum_d;
            write_q    <= write_d;
            loada_q    <= loada_d;
            loadb_q    <= loadb_d;
            loadc_q    <= loadc_d;
            loads_q    <= loads_d;
            asel_q     <= asel_d;
            vsel_q     <= vsel_d;
            shift_q    <= shift_d;
            aluop_q    <= aluop_d;
        end
    end

    assign w        = w_q;
    assign readnum  = readnum_q;
    assign writenum = writenum_q;
    assign asel     = asel_q;
    assign bsel     = 1'b0;
    assign vsel     = vsel_q;
    assign shift    = shift_q;
    assign aluop    = aluop_q;
    assign sximm8   = {{8{ir_q[7]}}, ir_q[7:0]};

    // Update strobes are masked by reset so an interrupted instruction
    // cannot modify the register file or datapath registers
    assign write = write_q & ~reset;
    assign loada = loada_q & ~reset;
    assign loadb = loadb_q & ~reset;
    assign loadc = loadc_q & ~reset;
    assign loads = loads_q & ~reset;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Directed bench for regfile_sequencer: drives instructions through a small
// register file / ALU model controlled by the sequencer's strobes, and
// checks strobes, latencies and resulting register contents.
module tb_regfile_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        s = 1'b0;
    logic [15:0] instr = 16'h0000;
    logic        w;
    logic [2:0]  readnum, writenum;
    logic        write, loada, loadb, loadc, loads, asel, bsel;
    logic [1:0]  vsel, shift, aluop;
    logic [15:0] sximm8;

    regfile_sequencer dut (
        .clk(clk), .reset(reset), .s(s), .in(instr), .w(w),
        .readnum(readnum), .writenum(writenum), .write(write),
        .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
        .asel(asel), .bsel(bsel), .vsel(vsel), .shift(shift),
        .aluop(aluop), .sximm8(sximm8)
    );

    always #5 clk = ~clk;

    logic [18:0] outs;
    logic [4:0]  strobes;
    assign outs    = {readnum, writenum, write, loada, loadb, loadc, loads,
                      asel, bsel, vsel, shift, aluop};
    assign strobes = {write, loada, loadb, loadc, loads};

    // Datapath model driven by the sequencer strobes
    logic        tb_clr = 1'b1;
    logic [15:0] rf [8];
    logic [15:0] a_r, b_r, c_r;
    logic        z_r;
    logic [15:0] bsh, ain, alu;

    always_comb begin
        case (shift)
            2'b01:   bsh = {b_r[14:0], 1'b0};
            2'b10:   bsh = {1'b0, b_r[15:1]};
            2'b11:   bsh = {b_r[15], b_r[15:1]};
            default: bsh = b_r;
        endcase
        ain = asel ? 16'h0000 : a_r;
        case (aluop)
            2'b00:   alu = ain + bsh;
            2'b01:   alu = ain - bsh;
            2'b10:   alu = ain & bsh;
            default: alu = ~bsh;
        endcase
    end

    always_ff @(posedge clk) begin
        if (tb_clr) begin
            for (int i = 0; i < 8; i++) rf[i] <= 16'h0000;
            a_r <= 16'h0000;
            b_r <= 16'h0000;
            c_r <= 16'h0000;
            z_r <= 1'b0;
        end else begin
            if (write) rf[writenum] <= (vsel == 2'b10) ? sximm8 : c_r;
            if (loada) a_r <= rf[readnum];
            if (loadb) b_r <= rf[readnum];
            if (loadc) c_r <= alu;
            if (loads) z_r <= (alu == 16'h0000);
        end
    end

    int n_chk = 0;
    int n_bad = 0;
    int edge_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        edge_cnt++;
    endtask

    // Present an instruction with s high for the accepting edge
    task automatic issue(input logic [15:0] x, input bit hold);
        instr = x;
        s = 1'b1;
        edge_cnt = 0;
        step();
        if (!hold) s = 1'b0;
    endtask

    task automatic wait_w(input string tag, input int exp_edges);
        while (!w && edge_cnt < 40) step();
        chk(tag, edge_cnt, exp_edges);
    endtask

    initial begin
        step();
        step();
        tb_clr = 1'b0;
        reset = 1'b0;
        chk("rst_w", w, 1);
        chk("rst_sx", sximm8, 16'h0000);
        chk("rst_outs", outs, 19'h0);

        // MOV R0,#7
        issue(16'hD007, 1'b0);
        chk("movi_dec_w", w, 0);
        chk("movi_dec_outs", outs, 19'h0);
        step();
        chk("movi_write", write, 1);
        chk("movi_wnum", writenum, 0);
        chk("movi_vsel", vsel, 2'b10);
        chk("movi_sx", sximm8, 16'h0007);
        wait_w("movi_lat", 3);
        chk("r0", rf[0], 16'h0007);

        // MOV R1,#-2
        issue(16'hD1FE, 1'b0);
        step();
        chk("movn_sx", sximm8, 16'hFFFE);
        chk("movn_wnum", writenum, 1);
        wait_w("movn_lat", 3);
        chk("r1", rf[1], 16'hFFFE);

        // ADD R2,R1,R0
        issue(16'hA140, 1'b0);
        step();
        chk("add_ga", {loada, loadb, readnum}, {1'b1, 1'b0, 3'd1});
        step();
        chk("add_gb", {loada, loadb, readnum}, {1'b0, 1'b1, 3'd0});
        step();
        chk("add_alu", {loadc, loads, asel, aluop}, {1'b1, 1'b0, 1'b0, 2'b00});
        step();
        chk("add_wr", {write, writenum, vsel}, {1'b1, 3'd2, 2'b00});
        wait_w("add_lat", 6);
        chk("r2", rf[2], 16'h0005);

        // CMP R0,R1 (7 - FFFE = 9, not zero)
        issue(16'hA801, 1'b0);
        step();
        chk("cmp_ga", {loada, readnum, write, loadc}, {1'b1, 3'd0, 2'b00});
        step();
        chk("cmp_gb", {loadb, readnum, write, loadc}, {1'b1, 3'd1, 2'b00});
        step();
        chk("cmp_alu", {loads, loadc, write, aluop}, {3'b100, 2'b01});
        wait_w("cmp_lat", 5);
        chk("cmp_z", z_r, 0);
        chk("cmp_r0", rf[0], 16'h0007);
        chk("cmp_r1", rf[1], 16'hFFFE);
        chk("cmp_r2", rf[2], 16'h0005);

        // CMP R0,R0 sets the zero flag
        issue(16'hA800, 1'b0);
        wait_w("cmp0_lat", 5);
        chk("cmp0_z", z_r, 1);

        // MOV R4,R0,LSL#1
        issue(16'hC088, 1'b0);
        step();
        chk("movr_gb", {loada, loadb, readnum}, {1'b0, 1'b1, 3'd0});
        step();
        chk("movr_alu", {asel, aluop, shift, loadc}, {1'b1, 2'b00, 2'b01, 1'b1});
        wait_w("movr_lat", 5);
        chk("r4", rf[4], 16'h000E);

        // MVN R5,R0
        issue(16'hB8A0, 1'b0);
        step();
        step();
        chk("mvn_alu", {asel, aluop, loadc}, {1'b1, 2'b11, 1'b1});
        wait_w("mvn_lat", 5);
        chk("r5", rf[5], 16'hFFF8);

        // AND R6,R1,R0
        issue(16'hB1C0, 1'b0);
        wait_w("and_lat", 6);
        chk("r6", rf[6], 16'h0006);

        // Unsupported encodings complete with no strobes
        issue(16'h0000, 1'b0);
        chk("uns_strobes", strobes, 5'b0);
        wait_w("uns_lat", 2);
        issue(16'hC800, 1'b0);
        chk("uns2_strobes", strobes, 5'b0);
        wait_w("uns2_lat", 2);

        // ADD R7,R0,R0 with s held high and in changed after capture
        issue(16'hA0E0, 1'b1);
        instr = 16'h0000;
        step();
        step();
        step();
        step();
        chk("hold_wr", {write, writenum}, {1'b1, 3'd7});
        wait_w("hold_lat", 6);
        chk("r7", rf[7], 16'h000E);
        step();
        chk("hold_acc", w, 0);
        step();
        chk("hold_uns", w, 1);
        s = 1'b0;
        step();
        chk("hold_idle", w, 1);

        // reset and s together in WAIT: nothing captured
        instr = 16'hD0FF;
        s = 1'b1;
        reset = 1'b1;
        step();
        reset = 1'b0;
        s = 1'b0;
        chk("rs_w", w, 1);
        chk("rs_sx", sximm8, 16'h0000);
        step();
        step();
        chk("rs_idle", {w, strobes}, {1'b1, 5'b0});
        chk("rs_r0", rf[0], 16'h0007);

        // reset during WR_REG of ADD R3,R0,R0
        issue(16'hA060, 1'b0);
        step();
        step();
        step();
        step();
        chk("rwr_pre", {write, writenum}, {1'b1, 3'd3});
        reset = 1'b1;
        #1;
        chk("rwr_write", write, 0);
        step();
        reset = 1'b0;
        chk("rwr_w", w, 1);
        chk("rwr_outs", outs, 19'h0);
        chk("r3", rf[3], 16'h0000);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
